apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Upstream stage of the APB memory slave: converts a simple valid/ready command stream into APB transfers (SETUP → ACCESS), waits on PREADY, and returns read data or an error on a valid/ready response stream.
- One outstanding transfer at a time.
- A wait-state timeout prevents a hung slave from stalling the command source.

Parameters:
- ADDR_W, 32, width of cmd_addr/PADDR
- DATA_W, 32, width of write/read data
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at PCLK edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR seen or timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error; tie 0 for slaves without it

Behaviour:
- Clock and reset: one clock PCLK; PRESETn asynchronous, active-low.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0.
- FSM states:
  - IDLE: cmd_ready=1 (only state where it is 1). On accept, register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
  - SETUP: PSEL=1, PENABLE=0; always lasts one cycle, then ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA and rsp_err = PSLVERR; go to RESP.
    - PREADY=0: increment the wait counter.
    - Timeout: if TIMEOUT_CYCLES≠0, PREADY=0, and the counter reaches TIMEOUT_CYCLES, abort with rsp_rdata=0, rsp_err=1, and go to RESP.
    - PREADY=1 in the same cycle the timeout would fire wins; it is a normal completion.
  - RESP: PSEL=PENABLE=0, rsp_valid=1, rsp_rdata/rsp_err stable. On rsp_ready=1, go to IDLE and clear the counter.
- APB stability: PADDR, PWRITE, PWDATA are unchanged from SETUP until the transfer ends, and keep their last value afterwards.
- PSEL/PENABLE are never both high outside ACCESS, and PENABLE is never high without PSEL.
- Latency: accept at edge N → SETUP in cycle N+1, ACCESS in N+2. With zero wait states, rsp_valid is high in cycle N+3.
- Throughput: best-case throughput with rsp_ready tied 1 is one transfer per 4 cycles.
- Each wait state adds one cycle.
- The wait counter is sized $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- cmd_* inputs are ignored outside IDLE.
- rsp_ready is ignored when rsp_valid=0.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, the transfer is dropped, and no response is generated.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}
  - default ADDR_W/DATA_W localparams
  - response struct {rdata, err}
- Optional sub-module apb_wait_timer: saturating counter with clear/enable inputs and a timeout flag. The rest stays flat.

Test Plan:
- Write: cmd write addr=0x10 wdata=0xDEADBEEF, PREADY=1 → PSEL=1 for 2 cycles, PENABLE in 2nd, PWRITE=1, PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid at N+3, rsp_rdata=0, rsp_err=0.
- Read: read addr=0x10, slave returns PRDATA=0xDEADBEEF with PREADY=1 → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid at N+3.
- Wait states: PREADY held 0 for 3 ACCESS cycles then 1, PRDATA=0x12345678 → rsp_valid at N+6; PADDR/PWRITE stable throughout; rsp_rdata=0x12345678.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 → abort after 4 ACCESS cycles, PSEL/PENABLE drop, rsp_err=1, rsp_rdata=0. Repeat with PREADY rising in the 4th cycle → normal completion, rsp_err=0.
- Backpressure and back-to-back: rsp_ready=0 for 5 cycles → rsp_valid/rsp_rdata hold and cmd_ready=0. After release, the second queued cmd_valid is accepted on the following IDLE cycle, and PSLVERR=1 on that transfer → rsp_err=1.
- Reset: PRESETn low during ACCESS → PSEL/PENABLE/rsp_valid 0 immediately. After release, cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB command master.
// State encoding, bus widths and the response bundle.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master_timer.sv
// Saturating wait-state counter for the APB master.
// Flags expiry on the last permitted stalled ACCESS cycle.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 0);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_cnt;
  logic          w_on;

  assign w_on     = (TIMEOUT_CYCLES != 0);
  assign o_expire = w_on && i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && r_cnt != MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB transfer converter.
// One transfer in flight; stalled slaves are aborted by timer.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_mst_state_e    r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_expire;

  assign w_tmr_clr = (r_state == RESP) && rsp_ready;
  assign w_tmr_en  = (r_state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_pwrite    <= cmd_write;
            r_paddr     <= cmd_addr;
            r_pwdata    <= cmd_wdata;
            r_psel      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY beats a timeout landing on the same cycle
          if (PREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_expire) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Randomised self-checking bench for apb_cmd_master.
// The bench acts as APB slave and response consumer.
module tb_apb_cmd_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK     (clk),
    .PRESETn  (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PADDR    (paddr),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Runs one transfer; waits = stalled ACCESS cycles before PREADY.
  task automatic xfer(
    input string       nm,
    input logic        wr,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input int          waits,
    input logic        slverr,
    input int          hold,
    input logic        queue_next,
    input logic [31:0] next_addr
  );
    int          acc;
    logic [31:0] exp_rd;
    logic        exp_err;
    if (waits >= T) begin
      acc     = T;
      exp_rd  = '0;
      exp_err = 1'b1;
    end else begin
      acc     = waits + 1;
      exp_rd  = wr ? 32'h0 : rdata;
      exp_err = slverr;
    end

    nchk++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL %s idle_ready got=%b exp=1", nm, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;

    nchk++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b1000) begin
      nerr++;
      $display("FAIL %s setup_ctl got=%b exp=1000", nm,
               {psel, penable, cmd_ready, rsp_valid});
    end
    nchk++;
    if ({pwrite, paddr, pwdata} !== {wr, addr, wdata}) begin
      nerr++;
      $display("FAIL %s setup_bus got=%b/%h/%h exp=%b/%h/%h", nm,
               pwrite, paddr, pwdata, wr, addr, wdata);
    end

    for (int j = 0; j < acc; j++) begin
      @(posedge clk); #1;
      nchk++;
      if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1100) begin
        nerr++;
        $display("FAIL %s access%0d_ctl got=%b exp=1100", nm, j,
                 {psel, penable, rsp_valid, cmd_ready});
      end
      nchk++;
      if ({pwrite, paddr, pwdata} !== {wr, addr, wdata}) begin
        nerr++;
        $display("FAIL %s access%0d_bus got=%h exp=%h", nm, j,
                 paddr, addr);
      end
      pready  = (j == waits);
      prdata  = (j == waits) ? rdata : $urandom;
      pslverr = (j == waits) ? slverr : 1'($urandom);
      if (queue_next) begin
        cmd_valid = 1'b1;
        cmd_addr  = $urandom;
      end
    end

    @(posedge clk); #1;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = $urandom;
    nchk++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0010) begin
      nerr++;
      $display("FAIL %s resp_ctl got=%b exp=0010", nm,
               {psel, penable, rsp_valid, cmd_ready});
    end
    nchk++;
    if ({rsp_rdata, rsp_err} !== {exp_rd, exp_err}) begin
      nerr++;
      $display("FAIL %s resp_data got=%h/%b exp=%h/%b", nm,
               rsp_rdata, rsp_err, exp_rd, exp_err);
    end
    if (queue_next) begin
      cmd_valid = 1'b1;
      cmd_write = ~wr;
      cmd_addr  = next_addr;
    end

    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      nchk++;
      if ({rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err, paddr}
          !== {1'b1, 1'b0, 1'b0, exp_rd, exp_err, addr}) begin
        nerr++;
        $display("FAIL %s hold%0d got=%b%b%b/%h/%b/%h", nm, h,
                 rsp_valid, cmd_ready, psel, rsp_rdata, rsp_err, paddr);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    nchk++;
    if ({rsp_valid, cmd_ready, psel, penable} !== 4'b0100) begin
      nerr++;
      $display("FAIL %s release got=%b exp=0100", nm,
               {rsp_valid, cmd_ready, psel, penable});
    end
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata,
         rsp_rdata} !== '0) begin
      nerr++;
      $display("FAIL reset_vals got=%b%b%b%b%b/%h/%h/%h", psel, penable,
               pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchk++;
    if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
      nerr++;
      $display("FAIL reset_idle got=%b exp=100",
               {cmd_ready, psel, rsp_valid});
    end
  endtask

  task automatic test_write();
    xfer("write", 1'b1, 32'h10, 32'hDEADBEEF, 32'hCAFEF00D,
         0, 1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_read();
    xfer("read", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF,
         0, 1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_wait_states();
    xfer("waits", 1'b0, 32'h44, 32'h0, 32'h12345678,
         3, 1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    xfer("timeout", 1'b0, 32'h80, 32'h0, 32'hAAAA5555,
         20, 1'b0, 1, 1'b0, 32'h0);
    xfer("timeout_wr", 1'b1, 32'h84, 32'h1111, 32'h0,
         T, 1'b0, 0, 1'b0, 32'h0);
    xfer("late_ready", 1'b0, 32'h88, 32'h0, 32'h0BADF00D,
         T - 1, 1'b0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back();
    xfer("b2b_first", 1'b0, 32'h200, 32'h0, 32'h55AA55AA,
         1, 1'b0, 5, 1'b1, 32'h204);
    xfer("b2b_second", 1'b1, 32'h204, 32'h77, 32'h0,
         0, 1'b1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      xfer("rand", 1'($urandom), $urandom, $urandom, $urandom,
           int'($urandom_range(0, 6)), 1'($urandom), 
           int'($urandom_range(0, 3)), 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h300;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    pready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({psel, penable, rsp_valid, paddr} !== {3'b000, 32'h0}) begin
      nerr++;
      $display("FAIL reset_mid got=%b%b%b/%h", psel, penable,
               rsp_valid, paddr);
    end
    pready  = 1'b1;
    prdata  = 32'hFFFF0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      nchk++;
      if ({cmd_ready, rsp_valid, psel, penable} !== 4'b1000) begin
        nerr++;
        $display("FAIL reset_post%0d got=%b exp=1000", k,
                 {cmd_ready, rsp_valid, psel, penable});
      end
    end
    pready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
